// File: rtl/uart_tx_fifo_sequencer.sv
// UART TX sequencer: drains an FWFT TX FIFO into the transmitter with flow control, gap and flush.
// Optional low-water interrupt enabled by defining TX_THRESHOLD_IRQ_EN.
module uart_tx_fifo_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int GAP_CYCLES = 0,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  flush_i,
    input  logic                  cts_i,
    input  logic                  fifo_empty_i,
    input  logic                  fifo_full_i,
    input  logic                  fifo_write_i,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                  fifo_read_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_start_o,
    input  logic                  tx_done_i,
    output logic                  busy_o,
    output logic                  flushing_o,
    input  logic [CW-1:0]         threshold_i,
    output logic                  thr_irq_o
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_BUSY,
        S_GAP,
        S_FLUSH
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [GW-1:0]   gap_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            gap_q     <= '0;
            tx_data_o <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                tx_data_o <= fifo_rd_data_i;
            end
            if (state_q == S_BUSY && tx_done_i) begin
                gap_q <= GAP_LOAD;
            end else if (state_q == S_GAP && gap_q != '0) begin
                gap_q <= gap_q - GW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // flush wins over a pending transmit
                if (flush_i) begin
                    state_d = S_FLUSH;
                end else if (enable_i && cts_i && !fifo_empty_i) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_START;
            S_START: state_d = S_BUSY;
            S_BUSY: begin
                if (tx_done_i) begin
                    state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (fifo_empty_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fifo_read_o = ((state_q == S_FETCH) || (state_q == S_FLUSH))
                         && !fifo_empty_i;
    assign tx_start_o  = (state_q == S_START);
    assign busy_o      = (state_q != S_IDLE);
    assign flushing_o  = (state_q == S_FLUSH);

`ifdef TX_THRESHOLD_IRQ_EN
    logic [CW-1:0] occ_q;
    logic          thr_q;
    logic          occ_inc;
    logic          occ_dec;

    assign occ_inc = fifo_write_i && !fifo_full_i;
    assign occ_dec = fifo_read_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q <= '0;
            thr_q <= 1'b0;
        end else begin
            if (occ_inc && !occ_dec && occ_q != CW'(FIFO_DEPTH)) begin
                occ_q <= occ_q + CW'(1);
            end else if (occ_dec && !occ_inc && occ_q != '0) begin
                occ_q <= occ_q - CW'(1);
            end
            thr_q <= (occ_q <= threshold_i);
        end
    end

    assign thr_irq_o = thr_q;
`else
    logic unused_thr;
    assign unused_thr = ^{threshold_i, fifo_write_i, fifo_full_i};
    assign thr_irq_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo_sequencer.sv
// Directed bench for uart_tx_fifo_sequencer: index 0 runs with no gap,
// index 1 with a 4-cycle inter-frame gap; each has its own FWFT FIFO model.
module tb_uart_tx_fifo_sequencer;

    localparam int CW = $clog2(32 + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic          cts = 1'b0;
    logic          done0 = 1'b0;
    logic          done1 = 1'b0;
    logic          push[2];
    logic [7:0]    pdata = '0;
    logic          fifo_clr = 1'b0;
    logic [CW-1:0] thr = CW'(2);

    logic          emp[2];
    logic [7:0]    rdat[2];
    logic          rd[2];
    logic          st[2];
    logic          bsy[2];
    logic          fl[2];
    logic          irq[2];
    logic [7:0]    txd[2];

    logic [7:0]    mem0[64];
    logic [7:0]    mem1[64];
    int            wp[2];
    int            rp[2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    initial begin
        push[0] = 1'b0;
        push[1] = 1'b0;
        wp[0] = 0;
        wp[1] = 0;
        rp[0] = 0;
        rp[1] = 0;
    end

    always @(posedge clk) begin
        if (fifo_clr) begin
            wp[0] <= 0;
            rp[0] <= 0;
            wp[1] <= 0;
            rp[1] <= 0;
        end else begin
            if (push[0]) begin
                mem0[wp[0][5:0]] <= pdata;
                wp[0] <= wp[0] + 1;
            end
            if (push[1]) begin
                mem1[wp[1][5:0]] <= pdata;
                wp[1] <= wp[1] + 1;
            end
            if (rd[0]) rp[0] <= rp[0] + 1;
            if (rd[1]) rp[1] <= rp[1] + 1;
        end
    end

    assign emp[0]  = (wp[0] == rp[0]);
    assign emp[1]  = (wp[1] == rp[1]);
    assign rdat[0] = mem0[rp[0][5:0]];
    assign rdat[1] = mem1[rp[1][5:0]];

    uart_tx_fifo_sequencer #(
        .DATA_WIDTH(8), .FIFO_DEPTH(32), .GAP_CYCLES(0)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .flush_i(flush),
        .cts_i(cts), .fifo_empty_i(emp[0]), .fifo_full_i(1'b0),
        .fifo_write_i(push[0]), .fifo_rd_data_i(rdat[0]),
        .fifo_read_o(rd[0]), .tx_data_o(txd[0]), .tx_start_o(st[0]),
        .tx_done_i(done0), .busy_o(bsy[0]), .flushing_o(fl[0]),
        .threshold_i(thr), .thr_irq_o(irq[0])
    );

    uart_tx_fifo_sequencer #(
        .DATA_WIDTH(8), .FIFO_DEPTH(32), .GAP_CYCLES(4)
    ) u_dut_gap (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .flush_i(flush),
        .cts_i(cts), .fifo_empty_i(emp[1]), .fifo_full_i(1'b0),
        .fifo_write_i(push[1]), .fifo_rd_data_i(rdat[1]),
        .fifo_read_o(rd[1]), .tx_data_o(txd[1]), .tx_start_o(st[1]),
        .tx_done_i(done1), .busy_o(bsy[1]), .flushing_o(fl[1]),
        .threshold_i(thr), .thr_irq_o(irq[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_word(input int k, input logic [7:0] d);
        push[k] = 1'b1;
        pdata = d;
        step();
        push[k] = 1'b0;
    endtask

    task automatic wait_start(input int k, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            step();
            if (st[k]) ok = 1'b1;
        end
    endtask

    task automatic run_idle(input int k, input int n,
                            output int nrd, output int nst);
        nrd = 0;
        nst = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (rd[k]) nrd++;
            if (st[k]) nst++;
        end
    endtask

    initial begin
        bit ok;
        int nrd, nst, sc, dc, fseen;
        logic [7:0] expw[3];
        expw[0] = 8'h11;
        expw[1] = 8'h22;
        expw[2] = 8'h33;

        repeat (3) step();
        rst = 1'b0;
        check("rst_busy", bsy[0], 0);
        check("rst_start", st[0], 0);
        check("rst_read", rd[0], 0);
        check("rst_data", txd[0], 0);
        check("rst_flushing", fl[0], 0);
        check("rst_irq", irq[0], 0);
        check("rst_busy_gap", bsy[1], 0);

        // basic transfer, no gap
        en = 1'b1;
        cts = 1'b1;
        push_word(0, 8'hA5);
        check("basic_idle_rd", rd[0], 0);
        check("basic_idle_st", st[0], 0);
        step();
        check("basic_fetch_rd", rd[0], 1);
        check("basic_fetch_st", st[0], 0);
        step();
        check("basic_start", st[0], 1);
        check("basic_data", txd[0], 8'hA5);
        check("basic_start_rd", rd[0], 0);
        step();
        check("basic_busy", bsy[0], 1);
        check("basic_busy_st", st[0], 0);
        done0 = 1'b1;
        step();
        done0 = 1'b0;
        check("basic_idle_after", bsy[0], 0);
        check("basic_hold_data", txd[0], 8'hA5);
        done0 = 1'b1;
        step();
        done0 = 1'b0;
        check("done_outside_busy", bsy[0], 0);

        // back-to-back with 4-cycle gap
        cts = 1'b0;
        push_word(1, 8'h11);
        push_word(1, 8'h22);
        push_word(1, 8'h33);
        cts = 1'b1;
        nst = 0;
        sc = -100;
        dc = -100;
        for (int c = 0; c < 80; c++) begin
            done1 = 1'b0;
            if (st[1]) begin
                if (nst < 3) check("gap_data", txd[1], expw[nst]);
                sc = c;
                nst++;
            end
            if (bsy[1] && c == sc + 2) begin
                done1 = 1'b1;
                dc = c;
            end
            if (rd[1] && dc >= 0) check("gap_fetch_dist", c - dc, 6);
            if (dc >= 0 && c == dc + 4) check("gap_busy", bsy[1], 1);
            if (dc >= 0 && c == dc + 5) check("gap_idle", bsy[1], 0);
            step();
        end
        done1 = 1'b0;
        check("gap_starts", nst, 3);
        check("gap_end_busy", bsy[1], 0);

        // flow control
        cts = 1'b0;
        push_word(0, 8'h3C);
        push_word(0, 8'h4D);
        run_idle(0, 50, nrd, nst);
        check("cts_low_rd", nrd, 0);
        check("cts_low_st", nst, 0);
        cts = 1'b1;
        wait_start(0, 10, ok);
        check("cts_start", ok, 1);
        check("cts_data", txd[0], 8'h3C);
        step();
        cts = 1'b0;
        repeat (5) step();
        check("cts_drop_busy", bsy[0], 1);
        done0 = 1'b1;
        step();
        done0 = 1'b0;
        check("cts_drop_done", bsy[0], 0);
        run_idle(0, 10, nrd, nst);
        check("cts_hold_rd", nrd, 0);
        cts = 1'b1;
        wait_start(0, 10, ok);
        check("cts_second", ok, 1);
        check("cts_data2", txd[0], 8'h4D);
        step();
        done0 = 1'b1;
        step();
        done0 = 1'b0;

        // flush in IDLE
        en = 1'b0;
        for (int i = 1; i <= 5; i++) push_word(0, 8'(i));
        check("nofeat_irq", irq[0], 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        nrd = 0;
        nst = 0;
        for (int c = 0; c < 12; c++) begin
            if (rd[0]) begin
                nrd++;
                check("flush_flag", fl[0], 1);
                check("flush_rd_empty", emp[0], 0);
            end
            if (st[0]) nst++;
            step();
        end
        check("flush_reads", nrd, 5);
        check("flush_starts", nst, 0);
        check("flush_end_fl", fl[0], 0);
        check("flush_end_busy", bsy[0], 0);

        // flush requested during BUSY
        en = 1'b1;
        push_word(0, 8'h5A);
        push_word(0, 8'hC3);
        wait_start(0, 10, ok);
        check("fbusy_start", ok, 1);
        check("fbusy_data", txd[0], 8'h5A);
        step();
        flush = 1'b1;
        repeat (3) step();
        check("fbusy_busy", bsy[0], 1);
        check("fbusy_not_fl", fl[0], 0);
        done0 = 1'b1;
        step();
        done0 = 1'b0;
        nrd = 0;
        nst = 0;
        fseen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (rd[0]) nrd++;
            if (st[0]) nst++;
            if (fl[0]) fseen++;
        end
        check("fbusy_reads", nrd, 1);
        check("fbusy_starts", nst, 0);
        check("fbusy_flushed", fseen > 0, 1);
        flush = 1'b0;
        step();
        step();
        check("fbusy_idle", bsy[0], 0);

        // reset mid-frame
        push_word(0, 8'h77);
        wait_start(0, 10, ok);
        check("rstm_start", ok, 1);
        step();
        #2 rst = 1'b1;
        #1;
        check("rstm_busy", bsy[0], 0);
        check("rstm_start0", st[0], 0);
        check("rstm_read", rd[0], 0);
        check("rstm_data", txd[0], 0);
        check("rstm_fl", fl[0], 0);
        fifo_clr = 1'b1;
        step();
        step();
        fifo_clr = 1'b0;
        rst = 1'b0;
        run_idle(0, 10, nrd, nst);
        check("rstm_no_start", nst, 0);
        check("rstm_no_read", nrd, 0);

`ifdef TX_THRESHOLD_IRQ_EN
        en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("thr_rst", irq[0], 0);
        step();
        check("thr_first", irq[0], 1);
        for (int i = 0; i < 4; i++) push_word(0, 8'(8'h40 + i));
        step();
        check("thr_four", irq[0], 0);
        en = 1'b1;
        wait_start(0, 10, ok);
        step();
        done0 = 1'b1;
        step();
        done0 = 1'b0;
        wait_start(0, 10, ok);
        check("thr_f2_start", ok, 1);
        check("thr_at_two", irq[0], 0);
        step();
        check("thr_after_two", irq[0], 1);
        step();
        done0 = 1'b1;
        step();
        done0 = 1'b0;
        step();
        check("thr_f3_fetch", rd[0], 1);
        push[0] = 1'b1;
        pdata = 8'h99;
        step();
        push[0] = 1'b0;
        step();
        step();
        check("thr_rw_same", irq[0], 1);
        en = 1'b0;
`else
        check("nofeat_irq_end", irq[0], 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
